// File: rtl/serial_subtractor.sv
// Multi-cycle X - Y - Bin, CHUNK bits per cycle, LSB slice first. out_valid rises W/CHUNK edges after accept.
// in_ready only in IDLE; the result is held in DONE for as long as out_ready stays low.
module serial_subtractor #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] D,
  output logic         Bout,
  output logic         OF
);

  localparam int N  = W / CHUNK;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic [W-1:0]  r_d;
  logic          r_bout;
  logic          r_of;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [CHUNK-1:0] w_xk;
  logic [CHUNK-1:0] w_yk;
  logic [CHUNK:0]   w_sum;

  // Subtraction as addition of the complement; carry-in is the inverted borrow.
  assign w_xk  = r_x[r_cnt*CHUNK +: CHUNK];
  assign w_yk  = r_y[r_cnt*CHUNK +: CHUNK];
  assign w_sum = {1'b0, w_xk} + {1'b0, ~w_yk} + {{CHUNK{1'b0}}, ~r_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_of        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= X;
            r_y        <= Y;
            r_borrow   <= Bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_d[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          r_borrow                  <= ~w_sum[CHUNK];
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_bout      <= ~w_sum[CHUNK];
            r_of        <= (r_x[W-1] ^ r_y[W-1]) & (w_sum[CHUNK-1] ^ r_x[W-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign Bout      = r_bout;
  assign OF        = r_of;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter W, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits processed per cycle; W SHALL be an integer multiple of CHUNK, and W >= 2*CHUNK.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands X, Y, Bin present.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 X  input  W  minuend, two's complement or unsigned.
REQ-008 Y  input  W  subtrahend.
REQ-009 Bin  input  1  borrow-in, subtracted from the result.
REQ-010 out_valid  output  1  D, Bout, OF hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 D  output  W  difference, X - Y - Bin mod 2^W.
REQ-013 Bout  output  1  unsigned borrow-out: 1 iff X < Y + Bin (unsigned).
REQ-014 OF  output  1  signed overflow: (X[W-1] ^ Y[W-1]) & (D[W-1] ^ X[W-1]).

Function
REQ-015 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on a rising edge with in_valid=1, latch X, Y, Bin into internal registers, clear slice counter to 0, load the internal borrow flag with Bin, go to BUSY.
REQ-018 IDLE with in_valid=0: hold state; D, Bout, OF keep their previous values.
REQ-019 BUSY: each cycle compute slice k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) as Xk + ~Yk + ~borrow, write it into D slice k, and set borrow = ~carry-out of that slice.
REQ-020 Slices SHALL be processed LSB first, k = 0 .. N-1, N = W/CHUNK; the counter increments once per BUSY cycle.
REQ-021 On the edge processing slice N-1: write final borrow to Bout, compute OF from latched X[W-1], Y[W-1] and the final D[W-1], go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly N rising edges after the accepting edge (4 for defaults).
REQ-023 X, Y, Bin, in_valid SHALL be ignored while in BUSY or DONE; latched operands SHALL not change.
REQ-024 DONE: D, Bout, OF held stable while out_valid=1 and out_ready=0 (backpressure of unbounded length).
REQ-025 DONE with out_ready=1 at an edge: go to IDLE; in_ready becomes 1 the following cycle (no same-cycle accept in DONE; max throughput one op per N+2 cycles).
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 D, Bout, OF SHALL be registered outputs; no combinational path from any input to any output.

Reset
REQ-028 rst_n=0 SHALL immediately (without clock) force state IDLE, in_ready=1, out_valid=0, D=0, Bout=0, OF=0, slice counter=0, borrow flag=0, operand registers=0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation; no result is produced for it after rst_n returns high.
REQ-030 After rst_n deasserts, the first rising edge SHALL be a normal IDLE edge (accepts in_valid=1).

Verification
REQ-031 W=32, CHUNK=8: X=5, Y=3, Bin=0 -> after 4 edges out_valid=1, D=0x00000002, Bout=0, OF=0.
REQ-032 X=3, Y=5, Bin=0 -> D=0xFFFFFFFE, Bout=1, OF=0; X=0, Y=0, Bin=1 -> D=0xFFFFFFFF, Bout=1, OF=0 (borrow ripples across all 4 slices).
REQ-033 X=0x80000000, Y=1, Bin=0 -> D=0x7FFFFFFF, Bout=0, OF=1; X=0x7FFFFFFF, Y=0xFFFFFFFF -> D=0x80000000, Bout=1, OF=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while changing X/Y/in_valid -> D, Bout, OF, out_valid unchanged, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 two cycles after accepting X=0x12345678, Y=1 -> outputs zero and in_ready=1 immediately; no out_valid afterwards; next op X=10, Y=4 -> D=6.
REQ-036 Random back-to-back ops (10^4, random Bin, random out_ready stalls) against a reference model of X-Y-Bin -> all D, Bout, OF match; latency always exactly 4.
